// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and its
// 11010-family detectors.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam logic [4:0] PAT_DEFAULT = 5'b11010;

endpackage

// File: rtl/pat_shreg.sv
// Loadable left-shift register; the MSB is the serial bit being transmitted.
module pat_shreg #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {r_sh[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sh[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first for a
// programmed number of repetitions with an optional idle gap between them.
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | emitting pattern bits, bit counter PAT_W-1 down to 0
//   GAP   | idle cycles between repetitions, gap counter down to 1
//   DONE  | run finished normally; done pulse is produced on leaving
module seq_pattern_tx #(
  parameter int unsigned      PAT_W       = 5,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = seq_pkg::PAT_DEFAULT,
  parameter int unsigned      CNT_W       = 8,
  parameter int unsigned      GAP_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_default,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             out_bit,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);

  import seq_pkg::*;

  localparam int unsigned     BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(PAT_W - 1);

  seq_state_e       r_state;
  logic [PAT_W-1:0] r_pat;
  logic [CNT_W-1:0] r_reps;
  logic [GAP_W-1:0] r_gap_len;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [BIT_W-1:0] r_bit_cnt;

  logic [PAT_W-1:0] w_sel_pat;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_load;
  logic             w_shift;
  logic             w_msb;

  assign w_sel_pat  = use_default ? PAT_DEFAULT : pattern;
  assign w_accept   = (r_state == IDLE) && start && (repeat_cnt != '0);
  assign w_last_bit = (r_state == SHIFT) && !abort && (r_bit_cnt == '0);

  // Reload on accept, on a back-to-back frame boundary, or at the end of a gap.
  assign w_load  = w_accept
                 || (w_last_bit && (r_reps != CNT_W'(1)) && (r_gap_len == '0))
                 || ((r_state == GAP) && !abort && (r_gap_cnt == GAP_W'(1)));
  assign w_shift = (r_state == SHIFT) && !abort;

  pat_shreg #(.W(PAT_W)) u_shreg (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  ((r_state == IDLE) ? w_sel_pat : r_pat),
    .o_msb   (w_msb)
  );

  // Outputs describe the state occupied during the cycle just ending, so the
  // first bit appears one edge after start is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_pat       <= '0;
      r_reps      <= '0;
      r_gap_len   <= '0;
      r_gap_cnt   <= '0;
      r_bit_cnt   <= '0;
      out_bit     <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      out_bit     <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            frames_sent <= '0;
            if (repeat_cnt != '0) begin
              r_pat     <= w_sel_pat;
              r_reps    <= repeat_cnt;
              r_gap_len <= gap_len;
              r_bit_cnt <= LAST_IDX;
              r_state   <= SHIFT;
            end else begin
              r_state <= DONE;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            r_state <= IDLE;
          end else begin
            out_valid   <= 1'b1;
            out_bit     <= w_msb;
            frame_start <= (r_bit_cnt == LAST_IDX);
            busy        <= 1'b1;
            if (r_bit_cnt != '0) begin
              r_bit_cnt <= r_bit_cnt - BIT_W'(1);
            end else begin
              r_bit_cnt <= LAST_IDX;
              r_reps    <= r_reps - CNT_W'(1);
              if (frames_sent != '1) frames_sent <= frames_sent + CNT_W'(1);
              if (r_reps == CNT_W'(1)) begin
                r_state <= DONE;
              end else if (r_gap_len != '0) begin
                r_gap_cnt <= r_gap_len;
                r_state   <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (abort) begin
            r_state <= IDLE;
          end else begin
            busy <= 1'b1;
            if (r_gap_cnt == GAP_W'(1)) r_state <= SHIFT;
            else r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        DONE: begin
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: per-cycle output stream compared
// against a frame-level model of the transmitted sequence.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       use_default = 1'b0;
  logic [4:0] pattern = '0;
  logic [7:0] repeat_cnt = '0;
  logic [3:0] gap_len = '0;
  logic       abort = 1'b0;
  logic       out_bit, out_valid, frame_start, busy, done;
  logic [7:0] frames_sent;

  int n_tests = 0;
  int n_fail  = 0;

  // {out_valid, out_bit, frame_start, busy, done, frames_sent[7:0]}
  logic [12:0] obs;
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];

  assign obs = {out_valid, out_bit, frame_start, busy, done, frames_sent};

  always #5 clk = ~clk;

  seq_pattern_tx dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .use_default (use_default),
    .pattern     (pattern),
    .repeat_cnt  (repeat_cnt),
    .gap_len     (gap_len),
    .abort       (abort),
    .out_bit     (out_bit),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent)
  );

  function automatic logic [12:0] pack(input logic v, input logic b, input logic fs,
                                       input logic bz, input logic d, input int fr);
    logic [7:0] f8;
    f8 = fr[7:0];
    return {v, b, fs, bz, d, f8};
  endfunction

  // Entry 0 is the cycle right after the accepting edge; each later entry is
  // one clock. Abort in cycle j only bites if the run is still busy in j+1.
  task automatic build_exp(input logic [4:0] p, input int r, input int g, input int abort_at);
    logic [12:0] e;
    int fr;
    exp_q.delete();
    exp_q.push_back(13'b0);
    for (int f = 0; f < r; f++) begin
      for (int i = 0; i < 5; i++)
        exp_q.push_back(pack(1'b1, p[4-i], i == 0, 1'b1, 1'b0, f + ((i == 4) ? 1 : 0)));
      if (f < r - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, f + 1));
    end
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, r));
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r));
    if (abort_at >= 0 && abort_at + 1 < exp_q.size()) begin
      e = exp_q[abort_at + 1];
      if (e[9]) begin
        e  = exp_q[abort_at];
        fr = int'(e[7:0]);
        while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fr));
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fr));
      end
    end
  endtask

  // Drives one run and records outputs at each negedge; noise toggles start
  // and scrambles the configuration inputs while the run is in progress.
  task automatic run_capture(input logic ud, input logic [4:0] p, input int r, input int g,
                             input int abort_at, input bit noise);
    logic [12:0] nxt;
    obs_q.delete();
    @(negedge clk);
    use_default = ud;
    pattern     = p;
    repeat_cnt  = 8'(r);
    gap_len     = 4'(g);
    start       = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clk);
      obs_q.push_back(obs);
      abort = (j == abort_at);
      start = 1'b0;
      if (noise && j + 1 < exp_q.size()) begin
        nxt = exp_q[j + 1];
        if (nxt[9] || nxt[8]) start = 1'($urandom_range(0, 1));
        pattern     = 5'($urandom);
        use_default = 1'($urandom);
        repeat_cnt  = 8'($urandom);
        gap_len     = 4'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    n_tests++;
    if (obs !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required %b", obs, 13'b0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if (obs !== 13'b0) begin
      n_fail++;
      $display("FAIL idle_abort: got %b required %b", obs, 13'b0);
    end
  endtask

  task automatic test_default_single;
    build_exp(5'b11010, 1, 0, -1);
    run_capture(1'b1, 5'b00101, 1, 0, -1, 1'b0);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_tests++;
      if (obs_q[j] !== exp_q[j]) begin
        n_fail++;
        $display("FAIL default_single[%0d]: got %b required %b", j, obs_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_back_to_back;
    build_exp(5'b11010, 3, 0, -1);
    run_capture(1'b0, 5'b11010, 3, 0, -1, 1'b1);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_tests++;
      if (obs_q[j] !== exp_q[j]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b required %b", j, obs_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_gap;
    build_exp(5'b10011, 2, 2, -1);
    run_capture(1'b0, 5'b10011, 2, 2, -1, 1'b0);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_tests++;
      if (obs_q[j] !== exp_q[j]) begin
        n_fail++;
        $display("FAIL gap[%0d]: got %b required %b", j, obs_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_zero_rep;
    build_exp(5'b11111, 0, 3, -1);
    run_capture(1'b0, 5'b11111, 0, 3, -1, 1'b1);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_tests++;
      if (obs_q[j] !== exp_q[j]) begin
        n_fail++;
        $display("FAIL zero_rep[%0d]: got %b required %b", j, obs_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_abort;
    logic [4:0] p;
    p = 5'($urandom);
    build_exp(p, 4, 0, 8);
    run_capture(1'b0, p, 4, 0, 8, 1'b1);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_tests++;
      if (obs_q[j] !== exp_q[j]) begin
        n_fail++;
        $display("FAIL abort[%0d]: got %b required %b", j, obs_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    use_default = 1'b1;
    repeat_cnt  = 8'd3;
    gap_len     = 4'd3;
    start       = 1'b1;
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_tests++;
    if (obs !== pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1)) begin
      n_fail++;
      $display("FAIL pre_reset_gap: got %b required %b", obs, pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1));
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (obs !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_mid_gap: got %b required %b", obs, 13'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    build_exp(5'b11010, 2, 1, -1);
    run_capture(1'b1, 5'b00000, 2, 1, -1, 1'b0);
    for (int j = 0; j < exp_q.size(); j++) begin
      n_tests++;
      if (obs_q[j] !== exp_q[j]) begin
        n_fail++;
        $display("FAIL after_reset[%0d]: got %b required %b", j, obs_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_random;
    logic [4:0] p;
    logic       ud;
    int         r, g, ab;
    for (int run = 0; run < 12; run++) begin
      p  = 5'($urandom);
      ud = 1'($urandom);
      r  = $urandom_range(0, 4);
      g  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 24) : -1;
      build_exp(ud ? 5'b11010 : p, r, g, ab);
      run_capture(ud, p, r, g, ab, 1'b1);
      for (int j = 0; j < exp_q.size(); j++) begin
        n_tests++;
        if (obs_q[j] !== exp_q[j]) begin
          n_fail++;
          $display("FAIL random%0d[%0d]: got %b required %b", run, j, obs_q[j], exp_q[j]);
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_default_single;
    test_back_to_back;
    test_gap;
    test_zero_rep;
    test_abort;
    test_reset_mid_run;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
